// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined instruction decode stage with register file, WB bypass,
// load-use hazard detection and flush.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready         IF -> ID handshake
//   in_instr, in_pc           instruction word and its PC from IF
//   wb_we, wb_rd, wb_data     register-file write port from WB
//   ex_memread, ex_rd         EX-stage load indication for load-use detection
//   flush                     kills the ID/EX payload and the current IF instruction
//   out_valid/out_ready       ID -> EX handshake
//   out_pc .. out_illegal     registered ID/EX payload
//   hazard_stall              combinational load-use stall indication
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter bit BYPASS    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [7:0]      out_ctrl,
    output logic            out_illegal,
    output logic            hazard_stall
);
    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]        opcode;
    logic [4:0]        rs1, rs2, rd;
    logic [AW-1:0]     rs1_idx, rs2_idx, wb_idx;
    logic [7:0]        ctrl;
    logic              illegal;
    logic              rs1_used, rs2_used;
    logic              hazard, adv;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm, rdata1, rdata2;
    logic [XLEN-1:0]   regs [REG_COUNT];

    assign opcode  = in_instr[6:0];
    assign rd      = in_instr[11:7];
    assign rs1     = in_instr[19:15];
    assign rs2     = in_instr[24:20];
    assign rs1_idx = rs1[AW-1:0];
    assign rs2_idx = rs2[AW-1:0];
    assign wb_idx  = wb_rd[AW-1:0];

    // ctrl = {RegWrite,MemRead,MemWrite,Branch,MemtoReg,ALUSrc,ALUOp[1:0]}
    always_comb begin
        ctrl    = (opcode == OP_R)      ? 8'b1000_0010 :
                  (opcode == OP_I)      ? 8'b1000_0110 :
                  (opcode == OP_LOAD)   ? 8'b1100_1100 :
                  (opcode == OP_STORE)  ? 8'b0010_0100 :
                  (opcode == OP_BRANCH) ? 8'b0001_0001 : 8'b0000_0000;
        illegal = !(opcode == OP_R || opcode == OP_I || opcode == OP_LOAD ||
                    opcode == OP_STORE || opcode == OP_BRANCH);
        rs1_used = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                   (opcode == OP_STORE) || (opcode == OP_BRANCH);
        rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    end

    // Immediates are assembled at 32 bits and then sign-extended to XLEN.
    always_comb begin
        imm32 = (opcode == OP_I || opcode == OP_LOAD || opcode == OP_JALR) ?
                    {{20{in_instr[31]}}, in_instr[31:20]} :
                (opcode == OP_STORE) ?
                    {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                (opcode == OP_BRANCH) ?
                    {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                (opcode == OP_LUI || opcode == OP_AUIPC) ?
                    {in_instr[31:12], 12'b0} :
                (opcode == OP_JAL) ?
                    {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                    32'sd0;
        imm = XLEN'(imm32);
    end

    // Asynchronous reads; index 0 is hard-wired to zero, WB optionally forwarded.
    always_comb begin
        rdata1 = (rs1_idx == '0) ? '0 :
                 (BYPASS && wb_we && wb_idx == rs1_idx) ? wb_data : regs[rs1_idx];
        rdata2 = (rs2_idx == '0) ? '0 :
                 (BYPASS && wb_we && wb_idx == rs2_idx) ? wb_data : regs[rs2_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_we && wb_idx != '0) begin
            regs[wb_idx] <= wb_data;
        end
    end

    assign hazard = in_valid && ex_memread && ex_rd != 5'd0 &&
                    ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
    assign hazard_stall = hazard;
    assign adv          = out_ready || !out_valid;
    // During a flush the IF instruction is consumed and discarded.
    assign in_ready     = flush || (adv && !hazard);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rdata1  <= '0;
            out_rdata2  <= '0;
            out_imm     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_ctrl    <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid && !hazard;
            if (!hazard) begin
                out_pc      <= in_pc;
                out_rdata1  <= rdata1;
                out_rdata2  <= rdata2;
                out_imm     <= imm;
                out_rs1     <= rs1;
                out_rs2     <= rs2;
                out_rd      <= rd;
                out_funct3  <= in_instr[14:12];
                out_funct7  <= in_instr[31:25];
                out_ctrl    <= ctrl;
                out_illegal <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed self-checking bench for id_stage_pipe (BYPASS=1 and BYPASS=0 instances).
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, out_ready, wb_we, ex_memread;
    logic [31:0] in_instr, in_pc, wb_data;
    logic [4:0]  wb_rd, ex_rd;

    logic        in_ready, out_valid, out_illegal, hazard_stall;
    logic [31:0] out_pc, out_rdata1, out_rdata2, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [7:0]  out_ctrl;

    logic        b0_in_ready, b0_out_valid, b0_out_illegal, b0_hazard_stall;
    logic [31:0] b0_out_pc, b0_out_rdata1, b0_out_rdata2, b0_out_imm;
    logic [4:0]  b0_out_rs1, b0_out_rs2, b0_out_rd;
    logic [2:0]  b0_out_funct3;
    logic [6:0]  b0_out_funct7;
    logic [7:0]  b0_out_ctrl;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .REG_COUNT(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_memread(ex_memread), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_ctrl(out_ctrl),
        .out_illegal(out_illegal), .hazard_stall(hazard_stall)
    );

    id_stage_pipe #(.XLEN(32), .REG_COUNT(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b0_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_memread(ex_memread), .ex_rd(ex_rd), .flush(flush),
        .out_valid(b0_out_valid), .out_ready(out_ready), .out_pc(b0_out_pc),
        .out_rdata1(b0_out_rdata1), .out_rdata2(b0_out_rdata2), .out_imm(b0_out_imm),
        .out_rs1(b0_out_rs1), .out_rs2(b0_out_rs2), .out_rd(b0_out_rd),
        .out_funct3(b0_out_funct3), .out_funct7(b0_out_funct7), .out_ctrl(b0_out_ctrl),
        .out_illegal(b0_out_illegal), .hazard_stall(b0_hazard_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        flush = 1'b0; out_ready = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        tick(); tick();
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        rst = 1'b1;
        tick();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", 64'(out_imm), 64'd5);
        chk("addi_ctrl", 64'(out_ctrl), 64'h86);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_pc", 64'(out_pc), 64'h100);

        in_instr = 32'h00018233; in_pc = 32'h104;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        tick();
        chk("bypass1_rdata1", 64'(out_rdata1), 64'hDEADBEEF);
        chk("bypass0_rdata1", 64'(b0_out_rdata1), 64'd0);
        chk("add_ctrl", 64'(out_ctrl), 64'h82);
        chk("add_rd", 64'(out_rd), 64'd4);
        wb_we = 1'b0;
        tick();
        chk("bypass0_after_write", 64'(b0_out_rdata1), 64'hDEADBEEF);

        in_instr = 32'h401102B3; in_pc = 32'h108;
        ex_memread = 1'b1; ex_rd = 5'd2;
        #1;
        chk("hz_stall", 64'(hazard_stall), 64'd1);
        chk("hz_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("hz_bubble", 64'(out_valid), 64'd0);
        ex_memread = 1'b0;
        #1;
        chk("hz_clear_ready", 64'(in_ready), 64'd1);
        tick();
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_rd", 64'(out_rd), 64'd5);
        chk("sub_funct7", 64'(out_funct7), 64'h20);
        chk("sub_rs1", 64'(out_rs1), 64'd2);
        chk("sub_rs2", 64'(out_rs2), 64'd1);

        ex_memread = 1'b1; ex_rd = 5'd0;
        #1;
        chk("hz_exrd0", 64'(hazard_stall), 64'd0);
        in_instr = 32'h00500093; ex_rd = 5'd5;
        #1;
        chk("hz_rs2_unused", 64'(hazard_stall), 64'd0);
        ex_memread = 1'b0;

        out_ready = 1'b0; in_pc = 32'h10C;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_rd_hold", 64'(out_rd), 64'd5);
        chk("stall_pc_hold", 64'(out_pc), 64'h108);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; out_ready = 1'b1;

        in_instr = 32'hFE208CE3; in_pc = 32'h110;
        tick();
        chk("beq_imm", 64'(out_imm), 64'hFFFFFFF8);
        chk("beq_ctrl", 64'(out_ctrl), 64'h11);
        chk("beq_illegal", 64'(out_illegal), 64'd0);
        in_instr = 32'h0000007F;
        tick();
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_ctrl", 64'(out_ctrl), 64'd0);
        chk("ill_valid", 64'(out_valid), 64'd1);
        in_instr = 32'h123450B7;
        tick();
        chk("lui_imm", 64'(out_imm), 64'h12345000);
        in_instr = 32'h0040A383;
        tick();
        chk("lw_ctrl", 64'(out_ctrl), 64'hCC);
        chk("lw_imm", 64'(out_imm), 64'd4);
        in_instr = 32'h0020A423;
        tick();
        chk("sw_ctrl", 64'(out_ctrl), 64'h24);
        chk("sw_imm", 64'(out_imm), 64'd8);

        in_instr = 32'h00000333; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        tick();
        chk("x0_same_cycle", 64'(out_rdata1), 64'd0);
        wb_we = 1'b0;
        tick();
        chk("x0_after", 64'(out_rdata1), 64'd0);
        chk("x0_after_nb", 64'(b0_out_rdata2), 64'd0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ctrl", 64'(out_ctrl), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
